pipeline_scoreboard: RTL and testbench
======================================

# pipeline_scoreboard

Issue-stage hazard controller for the in-order pipelined CPU. It sits between the decoder and the execute stage, tracks which registers have writes in flight, and holds an instruction at decode while a source register it reads is still pending writeback. It emits the issue strobe that advances the pipeline, a stall flag, and a register busy map. It also keeps a saturating stall counter for performance measurement.

## Interface

Parameters:

- PIPE_DEPTH, 3: cycles from issue to register-file writeback. A write is pending for PIPE_DEPTH cycles after issue. Legal range 1..8.
- NUM_REGS, 16: number of architectural registers. The selectors are 4 bits wide.
- STALL_CNT_W, 16: width of the stall counter.

Ports:

- i_clk  in  1  clock. There is one clock; the block is single clock domain.
- i_reset  in  1  reset, synchronous and active-high.
- i_valid  in  1  decode stage holds a valid instruction.
- i_re1  in  1  read enable, source 1 (decoder output).
- i_rs1  in  4  source register 1.
- i_re2  in  1  read enable, source 2.
- i_rs2  in  4  source register 2.
- i_we  in  1  instruction writes a register.
- i_ws  in  4  destination register.
- i_flush  in  1  squash all in-flight writes.
- o_issue  out  1  instruction accepted this cycle; decode may advance.
- o_stall  out  1  valid instruction held due to RAW hazard.
- o_busy  out  NUM_REGS  bit n set when register n has a pending write.
- o_stall_count  out  STALL_CNT_W  saturating count of stall cycles.

## Operation

- **State.** A shift register of PIPE_DEPTH slots. Each slot holds {valid, ws}.
  - Slot 0 is the youngest instruction.
  - Slot PIPE_DEPTH-1 is the instruction writing back this cycle.
- **Busy map.** o_busy[n] = OR over all slots of (slot.valid and slot.ws == n). It is combinational from slot state.
- **Hazard.** hazard = (i_re1 and o_busy[i_rs1]) or (i_re2 and o_busy[i_rs2]).
  - A source whose read enable is 0 never causes a hazard, whatever its selector value.
- **Issue and stall.**
  - o_issue = i_valid and not hazard and not i_flush.
  - o_stall = i_valid and hazard and not i_flush.
- **WAW is not a hazard.** The pipeline is in-order with fixed latency, so an instruction whose destination is busy issues freely.
- **Shift, every cycle (no downstream backpressure).**
  - Slot k+1 takes slot k.
  - Slot 0 takes {o_issue and i_we, i_ws}.
  - The valid bit of slot 0 is 0 when nothing issues, so a bubble is inserted.
- **Flush.**
  - All slot valid bits clear on the next edge.
  - There is no issue in the flush cycle.
  - The stall counter does not increment in the flush cycle.
- **Stall counter.**
  - Increments by 1 on each cycle with o_stall = 1.
  - Holds at 2^STALL_CNT_W - 1 and never wraps.
  - Cleared only by reset.
- **Priority.** Reset over flush, and flush over issue.

## Timing

- **Reset values.** After one i_reset cycle:
  - all slots are invalid;
  - o_busy = 0 and o_stall_count = 0;
  - o_stall = 0;
  - o_issue = i_valid, which is combinational.
- **Combinational outputs.** o_issue and o_stall are combinational from the inputs and registered state, in the same cycle. There is no added issue latency.
- **Busy window.**
  - An instruction issued with i_we = 1 at cycle t makes o_busy[ws] high for cycles t+1 through t+PIPE_DEPTH.
  - The bit clears at cycle t+PIPE_DEPTH+1, unless another in-flight write targets the same register.
- **Dependent issue.**
  - A dependent instruction presented at t+1 stalls for PIPE_DEPTH cycles and issues at t+PIPE_DEPTH+1.
  - The register file performs no write-to-read bypass in the writeback cycle, so slot PIPE_DEPTH-1 still counts as busy.
- **Simultaneous issue and retire to the same register.** The incoming write enters slot 0 while the old one leaves the last slot. The busy bit stays high with no gap.
- **Reset mid-stall.** The state clears on that edge. In the following cycle the held instruction issues if i_valid is still high.
- **Flush mid-stall.** o_issue is 0 in the flush cycle. The next cycle has an empty busy map, and the held instruction issues.

## Test plan

All scenarios use PIPE_DEPTH=3 unless noted.

1. **Reset.**
   - Stimulus: assert i_reset for 1 cycle with i_valid=1 and i_re1=1, i_rs1=2.
   - Required: next cycle o_busy=0x0000, o_stall=0, o_issue=1, o_stall_count=0.
2. **RAW stall.**
   - Stimulus: cycle 0 issue LDA (i_we=1, i_ws=2). Cycle 1 present ADD (re1=1, rs1=2, re2=1, rs2=1, ws=3) and hold it.
   - Required: o_stall=1 in cycles 1–3; o_issue=1 in cycle 4; o_busy[2]=1 in cycles 1–3 and 0 in cycle 4; o_stall_count=3.
3. **Independent and gated reads.**
   - Stimulus: after LDA r2, present ADD reading r5 and r6. Then present NOP with re1=0, rs1=2.
   - Required: both issue with no stall; o_stall_count is unchanged.
4. **Flush.**
   - Stimulus: cycle 0 LDA r2. Cycle 1 a dependent ADD with i_flush=1.
   - Required: o_issue=0 in cycle 1; o_busy=0 in cycle 2; the ADD issues in cycle 2; o_stall_count=0.
5. **Back-to-back same destination.**
   - Stimulus: LDA r7 at cycles 0 and 1.
   - Required: o_busy[7] high continuously for cycles 1–4, then 0 in cycle 5.
6. **Saturation.**
   - Stimulus: STALL_CNT_W=4, PIPE_DEPTH=3. Run 6 RAW pairs (3 stall cycles each, 18 total).
   - Required: o_stall_count reaches 15 and holds at 15 (0xF) with no wrap.

Source files
------------

// File: rtl/pipeline_scoreboard_if.sv
// pipeline_scoreboard_if
// Bundles the decode-side request signals and the hazard controller's
// responses between the decoder and the issue stage.
//   slave  : the scoreboard (takes i_*, drives o_*)
//   master : the decoder / bench (drives i_*, takes o_*)
interface pipeline_scoreboard_if #(
  parameter int NUM_REGS    = 16,
  parameter int STALL_CNT_W = 16
);
  logic                   i_valid;
  logic                   i_re1;
  logic [3:0]             i_rs1;
  logic                   i_re2;
  logic [3:0]             i_rs2;
  logic                   i_we;
  logic [3:0]             i_ws;
  logic                   i_flush;
  logic                   o_issue;
  logic                   o_stall;
  logic [NUM_REGS-1:0]    o_busy;
  logic [STALL_CNT_W-1:0] o_stall_count;

  modport slave (
    input  i_valid, i_re1, i_rs1, i_re2, i_rs2, i_we, i_ws, i_flush,
    output o_issue, o_stall, o_busy, o_stall_count
  );

  modport master (
    output i_valid, i_re1, i_rs1, i_re2, i_rs2, i_we, i_ws, i_flush,
    input  o_issue, o_stall, o_busy, o_stall_count
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard
// Issue-stage RAW hazard controller. Tracks in-flight register writes in a
// PIPE_DEPTH-slot shift register and holds a decoded instruction while any
// enabled source register still has a pending write.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous, active-high reset
//   sb      : decoder request / issue response bundle (slave side)
//             o_issue, o_stall combinational; o_busy combinational from slots;
//             o_stall_count saturating stall-cycle counter.
module pipeline_scoreboard #(
  parameter int PIPE_DEPTH  = 3,
  parameter int NUM_REGS    = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  pipeline_scoreboard_if.slave  sb
);
  localparam int SEL_W = 4;

  // Slot 0 is the youngest issue; slot PIPE_DEPTH-1 is writing back now.
  logic [PIPE_DEPTH-1:0]             vld_q, vld_d;
  logic [PIPE_DEPTH-1:0][SEL_W-1:0]  ws_q,  ws_d;
  logic [STALL_CNT_W-1:0]            cnt_q, cnt_d;

  logic [NUM_REGS-1:0] busy;
  logic                hazard;
  logic                issue;
  logic                stall;

  // The writeback slot still counts as busy: the register file has no
  // same-cycle write-to-read bypass.
  always_comb begin
    busy = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (vld_q[k]) busy[ws_q[k]] = 1'b1;
    end
  end

  // WAW is deliberately ignored: fixed latency keeps writes in order.
  assign hazard = (sb.i_re1 && busy[sb.i_rs1]) || (sb.i_re2 && busy[sb.i_rs2]);
  assign issue  = sb.i_valid && !hazard && !sb.i_flush;
  assign stall  = sb.i_valid &&  hazard && !sb.i_flush;

  always_comb begin
    vld_d    = '0;
    ws_d     = ws_q;
    vld_d[0] = issue && sb.i_we;   // bubble when nothing writes
    ws_d[0]  = sb.i_ws;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      ws_d[k]  = ws_q[k-1];
    end
    if (sb.i_flush) vld_d = '0;

    cnt_d = cnt_q;
    if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q <= '0;
      ws_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ws_q  <= ws_d;
      cnt_q <= cnt_d;
    end
  end

  assign sb.o_issue       = issue;
  assign sb.o_stall       = stall;
  assign sb.o_busy        = busy;
  assign sb.o_stall_count = cnt_q;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb_pipeline_scoreboard
// Directed vector table plus randomized traffic, checked against a
// per-register "busy until cycle" reference model. A second instance with a
// 4-bit stall counter shares the stimulus to exercise saturation.
module tb_pipeline_scoreboard;
  localparam int PD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_scoreboard_if #(.NUM_REGS(16), .STALL_CNT_W(16)) mif ();
  pipeline_scoreboard_if #(.NUM_REGS(16), .STALL_CNT_W(4))  sif ();

  assign sif.i_valid = mif.i_valid;
  assign sif.i_re1   = mif.i_re1;
  assign sif.i_rs1   = mif.i_rs1;
  assign sif.i_re2   = mif.i_re2;
  assign sif.i_rs2   = mif.i_rs2;
  assign sif.i_we    = mif.i_we;
  assign sif.i_ws    = mif.i_ws;
  assign sif.i_flush = mif.i_flush;

  pipeline_scoreboard #(.PIPE_DEPTH(PD), .NUM_REGS(16), .STALL_CNT_W(16)) u_dut (
    .i_clk(clk), .i_reset(rst), .sb(mif.slave));
  pipeline_scoreboard #(.PIPE_DEPTH(PD), .NUM_REGS(16), .STALL_CNT_W(4)) u_sat (
    .i_clk(clk), .i_reset(rst), .sb(sif.slave));

  typedef struct {
    bit rst, valid, re1; bit [3:0] rs1; bit re2; bit [3:0] rs2;
    bit we; bit [3:0] ws; bit flush;
    bit chk; bit eis, est; bit [15:0] ebusy; int ecnt;
  } vec_t;

  int nchk = 0, nerr = 0;

  // reference model: a register is busy while the current cycle number is
  // no later than the last cycle its newest write is still pending
  int busy_until[16];
  int cyc = 0;
  int mcnt = 0;

  function automatic bit [15:0] m_busy();
    bit [15:0] b = '0;
    for (int n = 0; n < 16; n++) b[n] = (cyc <= busy_until[n]);
    return b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit v, bit e1, bit [3:0] s1, bit e2, bit [3:0] s2,
                              bit w, bit [3:0] d, bit f, bit c, bit ei, bit es,
                              bit [15:0] eb, int ec);
    vec_t t;
    t.rst = r; t.valid = v; t.re1 = e1; t.rs1 = s1; t.re2 = e2; t.rs2 = s2;
    t.we = w; t.ws = d; t.flush = f; t.chk = c; t.eis = ei; t.est = es;
    t.ebusy = eb; t.ecnt = ec;
    return t;
  endfunction

  task automatic apply(input vec_t v);
    rst         = v.rst;
    mif.i_valid = v.valid; mif.i_re1 = v.re1; mif.i_rs1 = v.rs1;
    mif.i_re2   = v.re2;   mif.i_rs2 = v.rs2; mif.i_we  = v.we;
    mif.i_ws    = v.ws;    mif.i_flush = v.flush;
  endtask

  // one clock cycle: compare against the model (if chk), clock, advance model
  task automatic tick(input bit chk);
    bit [15:0] b;
    bit hz, is, st;
    int sat;
    #1;
    b   = m_busy();
    hz  = (mif.i_re1 && b[mif.i_rs1]) || (mif.i_re2 && b[mif.i_rs2]);
    is  = mif.i_valid && !hz && !mif.i_flush;
    st  = mif.i_valid &&  hz && !mif.i_flush;
    sat = (mcnt > 15) ? 15 : mcnt;
    if (chk) begin
      check("model_issue", int'(mif.o_issue), int'(is));
      check("model_stall", int'(mif.o_stall), int'(st));
      check("model_busy",  int'(mif.o_busy),  int'(b));
      check("model_cnt",   int'(mif.o_stall_count), mcnt);
      check("model_satcnt", int'(sif.o_stall_count), sat);
    end
    @(posedge clk);
    if (rst) begin
      for (int n = 0; n < 16; n++) busy_until[n] = -1;
      mcnt = 0;
    end else if (mif.i_flush) begin
      for (int n = 0; n < 16; n++) busy_until[n] = -1;
    end else begin
      if (is && mif.i_we) busy_until[mif.i_ws] = cyc + PD;
      if (st && mcnt < 65535) mcnt++;
    end
    cyc++;
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;
  bit   done;

  initial begin
    for (int n = 0; n < 16; n++) busy_until[n] = -1;
    //                r v e1 s1 e2 s2 we ws f chk is st busy     cnt
    tbl.push_back(mk(1,1,1, 2, 0, 0, 0, 0,0, 0, 0,0,16'h0000,0)); // reset
    tbl.push_back(mk(0,1,1, 2, 0, 0, 0, 0,0, 1, 1,0,16'h0000,0)); // post-reset
    tbl.push_back(mk(0,1,0, 0, 0, 0, 1, 2,0, 1, 1,0,16'h0000,0)); // LDA r2
    tbl.push_back(mk(0,1,1, 2, 1, 1, 1, 3,0, 1, 0,1,16'h0004,0)); // ADD stalls
    tbl.push_back(mk(0,1,1, 2, 1, 1, 1, 3,0, 1, 0,1,16'h0004,1));
    tbl.push_back(mk(0,1,1, 2, 1, 1, 1, 3,0, 1, 0,1,16'h0004,2));
    tbl.push_back(mk(0,1,1, 2, 1, 1, 1, 3,0, 1, 1,0,16'h0000,3)); // ADD issues
    tbl.push_back(mk(0,1,0, 0, 0, 0, 1, 2,0, 1, 1,0,16'h0008,3)); // LDA r2
    tbl.push_back(mk(0,1,1, 5, 1, 6, 1, 4,0, 1, 1,0,16'h000C,3)); // indep ADD
    tbl.push_back(mk(0,1,0, 2, 0, 0, 0, 0,0, 1, 1,0,16'h001C,3)); // gated NOP
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0014,3));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0010,3));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0000,3));
    tbl.push_back(mk(0,1,0, 0, 0, 0, 1, 2,0, 1, 1,0,16'h0000,3)); // LDA r2
    tbl.push_back(mk(0,1,1, 2, 0, 0, 1, 3,1, 1, 0,0,16'h0004,3)); // flush
    tbl.push_back(mk(0,1,1, 2, 0, 0, 1, 3,0, 1, 1,0,16'h0000,3)); // issues
    tbl.push_back(mk(0,1,0, 0, 0, 0, 1, 7,0, 1, 1,0,16'h0008,3)); // LDA r7
    tbl.push_back(mk(0,1,0, 0, 0, 0, 1, 7,0, 1, 1,0,16'h0088,3)); // LDA r7
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0088,3));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0080,3));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0080,3));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0000,3));
    tbl.push_back(mk(0,1,0, 0, 0, 0, 1, 9,0, 1, 1,0,16'h0000,3)); // LDA r9
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0200,3));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0200,3));
    tbl.push_back(mk(0,1,0, 0, 0, 0, 1, 9,0, 1, 1,0,16'h0200,3)); // issue+retire
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0200,3)); // no gap
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0200,3));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0200,3));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0,0, 1, 0,0,16'h0000,3));
    tbl.push_back(mk(0,1,0, 0, 0, 0, 1, 2,0, 1, 1,0,16'h0000,3)); // LDA r2
    tbl.push_back(mk(0,1,1, 2, 0, 0, 0, 0,0, 1, 0,1,16'h0004,3)); // stall
    tbl.push_back(mk(1,1,1, 2, 0, 0, 0, 0,0, 0, 0,1,16'h0004,4)); // reset mid-stall
    tbl.push_back(mk(0,1,1, 2, 0, 0, 0, 0,0, 1, 1,0,16'h0000,0)); // issues

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      v = tbl[i];
      apply(v);
      #1;
      if (v.chk) begin
        check($sformatf("vec%0d_issue", i), int'(mif.o_issue), int'(v.eis));
        check($sformatf("vec%0d_stall", i), int'(mif.o_stall), int'(v.est));
        check($sformatf("vec%0d_busy",  i), int'(mif.o_busy),  int'(v.ebusy));
        check($sformatf("vec%0d_cnt",   i), int'(mif.o_stall_count), v.ecnt);
      end
      tick(v.chk && (i > 0));
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom),
             4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)),
             ($urandom_range(0, 15) == 0), 1, 0, 0, 16'h0, 0);
      apply(v);
      tick(1);
    end

    // saturation: 6 RAW pairs of 3 stall cycles each on a 4-bit counter
    apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,16'h0,0));
    tick(1);
    for (int p = 0; p < 6; p++) begin
      apply(mk(0,1,0,0,0,0,1,1,0,1,0,0,16'h0,0)); // LDA r1
      tick(1);
      apply(mk(0,1,1,1,0,0,0,0,0,1,0,0,16'h0,0)); // dependent on r1
      done = 1'b0;
      for (int c = 0; c < 8 && !done; c++) begin
        #1;
        if (mif.o_issue) done = 1'b1;
        tick(1);
      end
      check($sformatf("pair%0d_issued", p), int'(done), 1);
      check($sformatf("pair%0d_satcnt", p), int'(sif.o_stall_count),
            (3 * (p + 1) > 15) ? 15 : 3 * (p + 1));
    end
    apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,16'h0,0));
    tick(1);
    check("sat_final", int'(sif.o_stall_count), 15);
    check("wide_final", int'(mif.o_stall_count), 18);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
